// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared widths and latency helpers for the adder tree
// accumulator (adder_tree_acc and its per-lane sub-module).
package adder_tree_pkg;

   localparam int DEF_IN_W   = 20;
   localparam int DEF_BIAS_W = 16;
   localparam int DEF_OUT_W  = 24;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // Register levels in the tree: at least one, even for a single input.
   function automatic int tree_lat(input int nin);
      int c;
      c = clog2(nin);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/adder_tree_acc_lane.sv
// adder_tree_acc_lane: one output channel -- pipelined pairwise adder tree
// over NIN signed inputs, a matching bias delay line and the tile
// accumulator. Optional clamp arithmetic under ADDER_TREE_ACC_SAT_EN.
module adder_tree_acc_lane
   import adder_tree_pkg::*;
#(
   parameter int NIN    = 3,
   parameter int IN_W   = DEF_IN_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NIN*IN_W-1:0]   data_i,
   input  logic [BIAS_W-1:0]     bias_i,
   input  logic                  acc_vld_i,
   input  logic                  acc_first_i,
   input  logic                  acc_last_i,
   output logic [OUT_W-1:0]      out_o,
   output logic                  sat_o
);

   localparam int TL = tree_lat(NIN);
   // Storage uses the final tree width; level l values only ever need IN_W+l bits.
   localparam int TW = IN_W + TL;
   // Twice NIN slots so the pair index 2j+1 never leaves the array; spare slots are zero.
   localparam int NS = 2 * NIN;

   logic signed [TW-1:0]     lvl    [TL+1][NS];
   logic signed [TW-1:0]     node_d [TL][NS];
   logic signed [TW-1:0]     node_q [TL][NS];
   logic signed [BIAS_W-1:0] bias_d [TL];
   logic signed [BIAS_W-1:0] bias_q [TL];

   logic signed [OUT_W-1:0]  tree_ext;
   logic signed [OUT_W-1:0]  bias_ext;
   logic signed [OUT_W-1:0]  base;
   logic signed [OUT_W-1:0]  acc_new;
   logic signed [OUT_W-1:0]  acc_d, acc_q;
   logic signed [OUT_W-1:0]  out_d, out_q;

`ifdef ADDER_TREE_ACC_SAT_EN
   logic signed [OUT_W:0]    wide;
   logic                     clamp;
   logic                     sat_d, sat_q;

   // Clamp an OUT_W+1 bit sum into the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] sat_clamp(input logic signed [OUT_W:0] x);
      if (x[OUT_W] != x[OUT_W-1])
         return x[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      else
         return x[OUT_W-1:0];
   endfunction

   // True when the OUT_W+1 bit sum does not fit in OUT_W bits.
   function automatic logic sat_hit(input logic signed [OUT_W:0] x);
      return x[OUT_W] != x[OUT_W-1];
   endfunction
`endif

   // Tree levels: level 0 is the sign-extended inputs, each next level adds neighbouring pairs.
   always_comb begin
      for (int l = 0; l <= TL; l++)
         for (int j = 0; j < NS; j++)
            lvl[l][j] = '0;
      for (int k = 0; k < NIN; k++)
         lvl[0][k] = TW'(signed'(data_i[k*IN_W +: IN_W]));
      for (int l = 1; l <= TL; l++)
         for (int j = 0; j < NS; j++)
            lvl[l][j] = node_q[l-1][j];
      for (int l = 0; l < TL; l++) begin
         for (int j = 0; j < NIN; j++)
            node_d[l][j] = lvl[l][2*j] + lvl[l][2*j+1];
         for (int j = NIN; j < NS; j++)
            node_d[l][j] = '0;
      end
      bias_d[0] = bias_i;
      for (int i = 1; i < TL; i++)
         bias_d[i] = bias_q[i-1];
   end

   // Accumulate on delayed valid: first reloads from bias, bubbles hold, last updates the output.
   always_comb begin
      tree_ext = OUT_W'(lvl[TL][0]);
      bias_ext = OUT_W'(bias_q[TL-1]);
      base     = acc_first_i ? bias_ext : acc_q;
`ifdef ADDER_TREE_ACC_SAT_EN
      wide     = (OUT_W+1)'(base) + (OUT_W+1)'(tree_ext);
      acc_new  = sat_clamp(wide);
      clamp    = sat_hit(wide);
      sat_d    = sat_q;
`else
      acc_new  = base + tree_ext;
`endif
      acc_d    = acc_q;
      out_d    = out_q;
      if (acc_vld_i) begin
         acc_d = acc_new;
         if (acc_last_i)
            out_d = acc_new;
`ifdef ADDER_TREE_ACC_SAT_EN
         sat_d = acc_first_i ? clamp : (sat_q | clamp);
`endif
      end
   end

   // Tree, bias delay line, accumulator and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int l = 0; l < TL; l++) begin
            for (int j = 0; j < NS; j++)
               node_q[l][j] <= '0;
            bias_q[l] <= '0;
         end
         acc_q <= '0;
         out_q <= '0;
      end else begin
         node_q <= node_d;
         bias_q <= bias_d;
         acc_q  <= acc_d;
         out_q  <= out_d;
      end
   end

`ifdef ADDER_TREE_ACC_SAT_EN
   // Sticky per-lane clamp indicator, restarted by each first beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sat_q <= 1'b0;
      else
         sat_q <= sat_d;
   end

   assign sat_o = sat_q;
`else
   assign sat_o = 1'b0;
`endif

   assign out_o = out_q;

endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: NCH independent lanes, each summing NIN signed PE products
// through a pipelined adder tree and accumulating across input tiles with a
// bias loaded on the first tile. Define ADDER_TREE_ACC_SAT_EN for clamping
// accumulation and a live sat_flag; otherwise arithmetic wraps.
module adder_tree_acc
   import adder_tree_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int NIN    = 3,
   parameter int IN_W   = DEF_IN_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    vld_i,
   input  logic                    first_i,
   input  logic                    last_i,
   input  logic [NCH*NIN*IN_W-1:0] iData,
   input  logic [NCH*BIAS_W-1:0]   iBias,
   output logic [NCH*OUT_W-1:0]    oOut,
   output logic                    out_vld,
   output logic [NCH-1:0]          sat_flag
);

   localparam int TL = tree_lat(NIN);

   logic [TL-1:0] vld_p_d,   vld_p_q;
   logic [TL-1:0] first_p_d, first_p_q;
   logic [TL-1:0] last_p_d,  last_p_q;
   logic          out_vld_d, out_vld_q;

   // Tag pipeline matching the tree depth; first/last only travel with a valid beat.
   always_comb begin
      vld_p_d[0]   = vld_i;
      first_p_d[0] = vld_i & first_i;
      last_p_d[0]  = vld_i & last_i;
      for (int i = 1; i < TL; i++) begin
         vld_p_d[i]   = vld_p_q[i-1];
         first_p_d[i] = first_p_q[i-1];
         last_p_d[i]  = last_p_q[i-1];
      end
      out_vld_d = vld_p_q[TL-1] & last_p_q[TL-1];
   end

   // Tag and output-valid registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p_q   <= '0;
         first_p_q <= '0;
         last_p_q  <= '0;
         out_vld_q <= 1'b0;
      end else begin
         vld_p_q   <= vld_p_d;
         first_p_q <= first_p_d;
         last_p_q  <= last_p_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign out_vld = out_vld_q;

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      adder_tree_acc_lane #(
         .NIN    (NIN),
         .IN_W   (IN_W),
         .BIAS_W (BIAS_W),
         .OUT_W  (OUT_W)
      ) u_lane (
         .clk         (clk),
         .rstn        (rstn),
         .data_i      (iData[c*NIN*IN_W +: NIN*IN_W]),
         .bias_i      (iBias[c*BIAS_W +: BIAS_W]),
         .acc_vld_i   (vld_p_q[TL-1]),
         .acc_first_i (first_p_q[TL-1]),
         .acc_last_i  (last_p_q[TL-1]),
         .out_o       (oOut[c*OUT_W +: OUT_W]),
         .sat_o       (sat_flag[c])
      );
   end

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed stimulus with a scoreboard queue; a monitor
// checks every out_vld pulse against the queued value, flags and cycle.
module tb_adder_tree_acc;

   localparam int NCH = 4, NIN = 3, IN_W = 20, BIAS_W = 16, OUT_W = 24;
   localparam int LAT = 3;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    vld_i, first_i, last_i;
   logic [NCH*NIN*IN_W-1:0] iData;
   logic [NCH*BIAS_W-1:0]   iBias;
   logic [NCH*OUT_W-1:0]    oOut;
   logic                    out_vld;
   logic [NCH-1:0]          sat_flag;

   adder_tree_acc #(.NCH(NCH), .NIN(NIN), .IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
      .iData(iData), .iBias(iBias), .oOut(oOut), .out_vld(out_vld), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NCH*OUT_W-1:0] val;
      logic [NCH-1:0]       sat;
      int                   cyc;
      string                name;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   logic [IN_W-1:0]   din [NCH][NIN];
   logic [BIAS_W-1:0] bin [NCH];

   task automatic setv(input int c, input int a, input int b, input int d, input int bias);
      din[c][0] = IN_W'(a);
      din[c][1] = IN_W'(b);
      din[c][2] = IN_W'(d);
      bin[c]    = BIAS_W'(bias);
   endtask

   task automatic drive(input logic v, input logic f, input logic l);
      @(negedge clk);
      vld_i = v; first_i = f; last_i = l;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < NIN; k++)
            iData[(c*NIN+k)*IN_W +: IN_W] = din[c][k];
         iBias[c*BIAS_W +: BIAS_W] = bin[c];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   // Call right after the beat carrying last; the result is due LAT cycles on.
   task automatic push(input string nm, input int e0, input int e1, input int e2, input int e3,
                       input logic [NCH-1:0] s);
      exp_t x;
      x.val = {OUT_W'(e3), OUT_W'(e2), OUT_W'(e1), OUT_W'(e0)};
      x.sat = s;
      x.cyc = cyc + LAT;
      x.name = nm;
      q.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every out_vld pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_vld === 1'b1) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_out_vld: got oOut %0h at cycle %0d, expected no output", oOut, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (oOut !== e.val || sat_flag !== e.sat || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL %s: got oOut %0h sat %0b cycle %0d, expected oOut %0h sat %0b cycle %0d",
                        e.name, oOut, sat_flag, cyc, e.val, e.sat, e.cyc);
            end
         end
      end
   end

   int ov_val;
   logic [NCH-1:0] ov_sat;

   initial begin
      rstn = 1'b0; vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; iData = '0; iBias = '0;
      for (int c = 0; c < NCH; c++) setv(c, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_oOut", 128'(oOut), 128'(0));
      chk("reset_out_vld", 128'(out_vld), 128'(0));
      chk("reset_sat_flag", 128'(sat_flag), 128'(0));
      rstn = 1'b1;
      idle(2);

      // Single tile: (1+c,2,3) + bias 10 -> 16+c
      for (int c = 0; c < NCH; c++) setv(c, 1 + c, 2, 3, 10);
      drive(1, 1, 1); push("single_tile", 16, 17, 18, 19, '0);
      idle(5);

      // Signed: (-5,-6,-7) + bias (-100-c) -> -118-c
      for (int c = 0; c < NCH; c++) setv(c, -5, -6, -7, -100 - c);
      drive(1, 1, 1); push("signed_tile", -118, -119, -120, -121, '0);
      idle(5);

      // Three tiles with bubbles: 3+6+9 + bias (4+c) -> 22+c
      for (int c = 0; c < NCH; c++) setv(c, 1, 1, 1, 4 + c);
      drive(1, 1, 0);
      idle(1);
      for (int c = 0; c < NCH; c++) setv(c, 2, 2, 2, 99);
      drive(1, 0, 0);
      idle(1);
      for (int c = 0; c < NCH; c++) setv(c, 3, 3, 3, 99);
      drive(1, 0, 1); push("three_tiles", 22, 23, 24, 25, '0);
      idle(5);

      // Back-to-back: A (1,2,3+c)+0 -> 6+c, then B (2,3,4)+(1+c) -> 10+c
      for (int c = 0; c < NCH; c++) setv(c, 1, 2, 3 + c, 0);
      drive(1, 1, 1); push("b2b_A", 6, 7, 8, 9, '0);
      for (int c = 0; c < NCH; c++) setv(c, 2, 3, 4, 1 + c);
      drive(1, 1, 1); push("b2b_B", 10, 11, 12, 13, '0);
      idle(5);

      // Overflow: six tiles of 3*524287 = 9437166 total, exceeds 2^23-1
`ifdef ADDER_TREE_ACC_SAT_EN
      ov_val = 8388607;  ov_sat = '1;
`else
      ov_val = -7340050; ov_sat = '0;
`endif
      for (int c = 0; c < NCH; c++) setv(c, 524287, 524287, 524287, 0);
      for (int t = 0; t < 6; t++) drive(1, t == 0, t == 5);
      push("overflow", ov_val, ov_val, ov_val, ov_val, ov_sat);
      idle(5);

      // Next first beat clears the sticky flag
      for (int c = 0; c < NCH; c++) setv(c, 1 + c, 2, 3, 10);
      drive(1, 1, 1); push("after_overflow", 16, 17, 18, 19, '0);
      idle(5);

      // Restart: first while open discards the partial; (1+c,2,3)+(10+c) -> 16+2c
      for (int c = 0; c < NCH; c++) setv(c, 1, 1, 1, 50);
      drive(1, 1, 0);
      for (int c = 0; c < NCH; c++) setv(c, 1 + c, 2, 3, 10 + c);
      drive(1, 1, 1); push("restart", 16, 18, 20, 22, '0);
      idle(5);

      // Reset after tile 2 of 3: nothing comes out, state returns to zero
      for (int c = 0; c < NCH; c++) setv(c, 1, 1, 1, 4);
      drive(1, 1, 0);
      for (int c = 0; c < NCH; c++) setv(c, 2, 2, 2, 4);
      drive(1, 0, 0);
      @(negedge clk);
      vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_oOut", 128'(oOut), 128'(0));
      chk("midreset_out_vld", 128'(out_vld), 128'(0));
      chk("midreset_sat_flag", 128'(sat_flag), 128'(0));
      rstn = 1'b1;
      idle(4);
      for (int c = 0; c < NCH; c++) setv(c, 1 + c, 2, 3, 10);
      drive(1, 1, 1); push("after_reset", 16, 17, 18, 19, '0);
      idle(6);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 128'(q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
